// File: rtl/qpimem_dma_pkg.sv
`default_nettype none
// ============================================================================
// qpimem_dma_pkg : shared constants, state type and burst helper
// Revision 1.0
// ============================================================================
package qpimem_dma_pkg;

    localparam int QPI_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BURST   = 2'b01,
        ST_RESTART = 2'b10
    } wr_state_t;

    // Words left before the drain index crosses the next burst-aligned boundary.
    function automatic int unsigned words_to_boundary(input int unsigned idx,
                                                      input int unsigned burst_len);
        return burst_len - (idx & (burst_len - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/qpimem_dma_wr_if.sv
`default_nettype none
// ============================================================================
// qpimem_dma_wr_if : write port between the DMA and the QPI memory controller
// Revision 1.0
// ============================================================================
interface qpimem_dma_wr_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  qpi_do_write;
    logic                  qpi_next_word;
    logic [ADDR_WIDTH-1:0] qpi_addr;
    logic [31:0]           qpi_wdata;
    logic                  qpi_is_idle;

    modport master (
        output qpi_do_write,
        output qpi_addr,
        output qpi_wdata,
        input  qpi_next_word,
        input  qpi_is_idle
    );

    modport slave (
        input  qpi_do_write,
        input  qpi_addr,
        input  qpi_wdata,
        output qpi_next_word,
        output qpi_is_idle
    );
endinterface
`default_nettype wire

// File: rtl/qpimem_dma_wr_fifomem.sv
`default_nettype none
// ============================================================================
// qpimem_dma_wr_fifomem : WORDS x 32 RAM, synchronous write, asynchronous read
// Revision 1.0
// ============================================================================
module qpimem_dma_wr_fifomem #(
    parameter int WORDS = 512,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  wire logic             clk,
    input  wire logic             we,
    input  wire logic [IDX_W-1:0] waddr,
    input  wire logic [31:0]      wdata,
    input  wire logic [IDX_W-1:0] raddr,
    output logic      [31:0]      rdata
);
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/qpimem_dma_wr.sv
`default_nettype none
// ============================================================================
// qpimem_dma_wr : buffered write DMA, producer stream -> FIFO -> QPI bursts
// Revision 1.0
// ============================================================================
module qpimem_dma_wr
    import qpimem_dma_pkg::*;
#(
    parameter int FIFO_WORDS = 512,
    parameter int BURST_LEN  = 16,
    parameter int ADDR_WIDTH = 24
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [ADDR_WIDTH-1:0] addr_start,
    input  wire logic [ADDR_WIDTH-1:0] addr_end,
    input  wire logic                  run,
    output logic                       ready,
    output logic                       all_done,
    input  wire logic                  do_write,
    input  wire logic [31:0]           wdata,
    qpimem_dma_wr_if.master            qpi
);
    localparam int                    IDX_W      = $clog2(FIFO_WORDS);
    localparam int                    WORD_SHIFT = $clog2(QPI_WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(QPI_WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(QPI_WORD_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] FIFO_CAP   = ADDR_WIDTH'(FIFO_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

    wr_state_t             state, state_nx;
    logic [ADDR_WIDTH-1:0] in_addr, in_addr_nx;
    logic [ADDR_WIDTH-1:0] drain_addr, drain_addr_nx;

    logic [ADDR_WIDTH-1:0] start_al, end_al, fill, drain_next, to_boundary;
    logic [IDX_W-1:0]      in_idx, drain_idx;
    logic                  push, last_word, start_burst, burst_on, restarting;

    assign start_al   = addr_start & ALIGN_MASK;
    assign end_al     = addr_end & ALIGN_MASK;
    assign in_idx     = in_addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
    assign drain_idx  = drain_addr[IDX_W+WORD_SHIFT-1:WORD_SHIFT];
    assign fill       = (in_addr - drain_addr) >> WORD_SHIFT;
    assign drain_next = drain_addr + WORD_STEP;
    assign burst_on   = (state == ST_BURST);
    assign restarting = (state == ST_RESTART);

    assign to_boundary = ADDR_WIDTH'(words_to_boundary(32'(drain_idx), BURST_LEN));

    assign ready = run && !restarting && (in_addr < end_al) && (fill < FIFO_CAP);
    assign push  = ready && do_write;

    // A burst stops at a burst boundary, at the range end, or when it would
    // overtake the producer (the last staged word with no push arriving).
    assign last_word = (to_boundary == ONE)
                    || (drain_next >= end_al)
                    || ((drain_next == in_addr) && !push);

    assign start_burst = qpi.qpi_is_idle && !burst_on && (drain_addr < end_al)
                      && ((fill >= to_boundary) || ((in_addr >= end_al) && (fill != '0)));

    assign all_done = (in_addr >= end_al) && (drain_addr >= end_al)
                   && qpi.qpi_is_idle && !burst_on && !restarting;

    always_comb begin
        state_nx      = state;
        in_addr_nx    = in_addr;
        drain_addr_nx = drain_addr;

        if (push) begin
            in_addr_nx = in_addr + WORD_STEP;
        end

        if (!run) begin
            in_addr_nx    = start_al;
            drain_addr_nx = start_al;
            state_nx      = ST_RESTART;
        end else begin
            case (state)
                ST_RESTART: begin
                    if (qpi.qpi_is_idle) begin
                        state_nx = ST_IDLE;
                    end
                end
                default: begin
                    if (qpi.qpi_next_word) begin
                        drain_addr_nx = drain_next;
                        if (last_word) begin
                            state_nx = ST_IDLE;
                        end
                    end else if (start_burst) begin
                        state_nx = ST_BURST;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_RESTART;
            in_addr    <= '0;
            drain_addr <= '0;
        end else begin
            state      <= state_nx;
            in_addr    <= in_addr_nx;
            drain_addr <= drain_addr_nx;
        end
    end

    assign qpi.qpi_do_write = burst_on;
    assign qpi.qpi_addr     = drain_addr;

    qpimem_dma_wr_fifomem #(
        .WORDS (FIFO_WORDS),
        .IDX_W (IDX_W)
    ) u_fifomem (
        .clk   (clk),
        .we    (push),
        .waddr (in_idx),
        .wdata (wdata),
        .raddr (drain_idx),
        .rdata (qpi.qpi_wdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_qpimem_dma_wr.sv
`default_nettype none
// ============================================================================
// tb_qpimem_dma_wr : directed self-checking bench for qpimem_dma_wr
// Revision 1.0
// ============================================================================
module tb_qpimem_dma_wr;
    logic        clk;
    logic        rst;
    logic [23:0] addr_start;
    logic [23:0] addr_end;
    logic        run;
    logic        ready;
    logic        all_done;
    logic        do_write;
    logic [31:0] wdata;
    logic        ctl_idle;
    logic        ctl_ack;

    int checks;
    int failures;

    logic [7:0]  tag;
    logic [23:0] push_addr;

    // Controller model: acks every cycle a burst is requested, idle otherwise.
    qpimem_dma_wr_if #(.ADDR_WIDTH(24)) qif ();
    assign qif.qpi_next_word = ctl_ack && qif.qpi_do_write;
    assign qif.qpi_is_idle   = ctl_idle && !qif.qpi_do_write;

    qpimem_dma_wr #(
        .FIFO_WORDS (512),
        .BURST_LEN  (16),
        .ADDR_WIDTH (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr_start (addr_start),
        .addr_end   (addr_end),
        .run        (run),
        .ready      (ready),
        .all_done   (all_done),
        .do_write   (do_write),
        .wdata      (wdata),
        .qpi        (qif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side monitor: captures written words and burst starts/lengths.
    logic [31:0] bmem [4096];
    logic [23:0] bstart [128];
    int          blen [128];
    int          nb;
    int          wcount;
    int          cur_len;
    logic        prev_dw;
    logic [23:0] hi;

    always @(negedge clk) begin
        if (!rst) begin
            nb      <= 0;
            wcount  <= 0;
            cur_len <= 0;
            prev_dw <= 1'b0;
            hi      <= '0;
        end else begin
            prev_dw <= qif.qpi_do_write;
            if (qif.qpi_do_write && !prev_dw && nb < 128) begin
                bstart[nb] <= qif.qpi_addr;
            end
            if (qif.qpi_next_word) begin
                bmem[qif.qpi_addr[13:2]] <= qif.qpi_wdata;
                wcount <= wcount + 1;
                if (qif.qpi_addr > hi) begin
                    hi <= qif.qpi_addr;
                end
            end
            if (!qif.qpi_do_write && prev_dw) begin
                if (nb < 128) begin
                    blen[nb] <= cur_len;
                end
                nb      <= nb + 1;
                cur_len <= 0;
            end else if (qif.qpi_next_word) begin
                cur_len <= cur_len + 1;
            end
        end
    end

    function automatic logic [31:0] wval(input logic [7:0] t, input logic [23:0] a);
        return {t, a};
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic apply_reset();
        run      = 1'b0;
        do_write = 1'b0;
        ctl_idle = 1'b1;
        ctl_ack  = 1'b1;
        rst      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic arm(input logic [23:0] s, input logic [23:0] e, input logic [7:0] t);
        addr_start = s;
        addr_end   = e;
        tag        = t;
        push_addr  = s;
        run        = 1'b0;
        @(negedge clk);
        run = 1'b1;
        for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
        check_bit("armed_ready", ready, 1'b1);
    endtask

    task automatic push_run(input int n, input int max_cycles, output int acc);
        acc = 0;
        for (int k = 0; k < max_cycles && acc < n; k++) begin
            @(negedge clk);
            wdata    = wval(tag, push_addr);
            do_write = 1'b1;
            if (ready) begin
                acc++;
                push_addr = push_addr + 24'd4;
            end
        end
        @(negedge clk);
        do_write = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && !all_done; k++) @(negedge clk);
        check_bit("all_done", all_done, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [23:0] a;
            a = base + 24'(4 * i);
            check("mem_data", bmem[a[13:2]], wval(tag, a));
        end
    endtask

    initial begin
        int acc;
        int nb0;
        int wc0;
        checks     = 0;
        failures   = 0;
        addr_start = '0;
        addr_end   = '0;
        wdata      = '0;
        tag        = '0;
        push_addr  = '0;
        run        = 1'b0;
        do_write   = 1'b0;
        ctl_idle   = 1'b1;
        ctl_ack    = 1'b1;
        rst        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_do_write", qif.qpi_do_write, 1'b0);
        check("rst_qpi_addr", {8'h0, qif.qpi_addr}, 32'h0);
        check_bit("rst_all_done", all_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // 1: full-range aligned transfer, four 16-word bursts
        apply_reset();
        arm(24'h000100, 24'h000200, 8'h11);
        push_run(64, 200, acc);
        check("t1_accepted", acc, 64);
        wait_done(200);
        check("t1_bursts", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_bstart", {8'h0, bstart[i]}, 32'h100 + 32'(i * 32'h40));
            check("t1_blen", blen[i], 16);
        end
        check("t1_words", wcount, 64);
        check_mem(24'h000100, 64);

        // 2: misaligned start, short first burst, tail flush
        apply_reset();
        arm(24'h000108, 24'h000148, 8'h22);
        push_run(16, 100, acc);
        wait_done(200);
        check("t2_bursts", nb, 2);
        check("t2_bstart0", {8'h0, bstart[0]}, 32'h108);
        check("t2_blen0", blen[0], 14);
        check("t2_bstart1", {8'h0, bstart[1]}, 32'h140);
        check("t2_blen1", blen[1], 2);
        check("t2_hi_addr", {8'h0, hi}, 32'h144);
        check("t2_words", wcount, 16);
        check_mem(24'h000108, 16);

        // 3: controller busy, FIFO fills to exactly 512, then drains
        apply_reset();
        arm(24'h001000, 24'h002000, 8'h33);
        ctl_idle = 1'b0;
        ctl_ack  = 1'b0;
        push_run(520, 520, acc);
        check("t3_accepted_full", acc, 512);
        check_bit("t3_ready_full", ready, 1'b0);
        check_bit("t3_no_burst", qif.qpi_do_write, 1'b0);
        ctl_idle = 1'b1;
        ctl_ack  = 1'b1;
        push_run(512, 3000, acc);
        check("t3_accepted_rest", acc, 512);
        wait_done(3000);
        check("t3_words", wcount, 1024);
        check("t3_bursts", nb, 64);
        check_mem(24'h001000, 1024);

        // 4: slow producer, 5-word range, single tail flush
        apply_reset();
        arm(24'h000200, 24'h000214, 8'h44);
        for (int i = 0; i < 4; i++) begin
            push_run(1, 50, acc);
            repeat (9) @(negedge clk);
        end
        check("t4_no_early_burst", nb, 0);
        check_bit("t4_dw_low", qif.qpi_do_write, 1'b0);
        push_run(1, 50, acc);
        wait_done(100);
        check("t4_bursts", nb, 1);
        check("t4_bstart", {8'h0, bstart[0]}, 32'h200);
        check("t4_blen", blen[0], 5);
        check("t4_words", wcount, 5);
        check_mem(24'h000200, 5);

        // 5: abort mid-burst, wait for idle, restart at 0x400
        apply_reset();
        arm(24'h000300, 24'h000400, 8'h55);
        push_run(20, 100, acc);
        for (int k = 0; k < 100 && wcount < 3; k++) @(negedge clk);
        check_bit("t5_mid_burst", qif.qpi_do_write, 1'b1);
        run        = 1'b0;
        ctl_idle   = 1'b0;
        ctl_ack    = 1'b0;
        addr_start = 24'h000400;
        addr_end   = 24'h000440;
        @(negedge clk);
        check_bit("t5_dw_fell", qif.qpi_do_write, 1'b0);
        check("t5_qpi_addr_rearm", {8'h0, qif.qpi_addr}, 32'h400);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_bit("t5_ready_busy", ready, 1'b0);
        end
        ctl_idle = 1'b1;
        ctl_ack  = 1'b1;
        for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
        check_bit("t5_ready_idle", ready, 1'b1);
        tag       = 8'h5B;
        push_addr = 24'h000400;
        nb0       = nb;
        wc0       = wcount;
        push_run(16, 100, acc);
        wait_done(200);
        check("t5_words", wcount - wc0, 16);
        check("t5_bstart", {8'h0, bstart[nb0]}, 32'h400);
        check_mem(24'h000400, 16);

        // 6: asynchronous reset between clock edges during a burst
        apply_reset();
        arm(24'h000100, 24'h000200, 8'h66);
        push_run(20, 100, acc);
        check_bit("t6_mid_burst", qif.qpi_do_write, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_bit("t6_dw_async", qif.qpi_do_write, 1'b0);
        check("t6_addr_async", {8'h0, qif.qpi_addr}, 32'h0);
        check_bit("t6_ready_async", ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qpimem_dma_wr.md
# qpimem_dma_wr

Buffered, write-only DMA from a streaming producer into QPI memory. It is the write-side counterpart of the QPI DMA reader and sits between a data source (e.g. a capture or audio engine) and the QPI memory controller's write port. Incoming words are staged in a block-RAM FIFO and drained to memory in aligned bursts, covering a byte range `[addr_start, addr_end)`.

## Interface
- `FIFO_WORDS`, 512: FIFO depth in 32-bit words. Power of 2; `FIFO_WORDS*4 < 2^ADDR_WIDTH`.
- `BURST_LEN`, 16: maximum burst length in words. Power of 2, ≤ `FIFO_WORDS`, ≤ 32 for interleaved psram at 48 MHz.
- `ADDR_WIDTH`, 24: QPI byte-address width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `addr_start` in ADDR_WIDTH: first byte address. Bits [1:0] are ignored (treated as 0).
- `addr_end` in ADDR_WIDTH: byte address one past the last byte. Bits [1:0] are ignored.
- `run` in 1: high starts or continues the transfer. Low aborts it and rearms the block.
- `ready` out 1: the FIFO can accept a word this cycle.
- `all_done` out 1: every word in the range has been written to memory and the QPI controller is idle.
- `do_write` in 1: push strobe. It takes effect only when `ready` is high.
- `wdata` in 32: word to push.
- `qpi_do_write` out 1: requests or holds a QPI write burst (registered).
- `qpi_next_word` in 1: the controller consumed `qpi_wdata`.
- `qpi_addr` out ADDR_WIDTH: byte address of the current memory word (registered).
- `qpi_wdata` out 32: FIFO word at `qpi_addr`.
- `qpi_is_idle` in 1: the controller has no transaction in progress.

## Operation
Internal state:
- `in_addr`: producer byte pointer.
- `qpi_addr`: drain byte pointer.
- `restarting` flag.

FIFO indices are `addr[log2(FIFO_WORDS)+1:2]`. Fill level is `fill = (in_addr - qpi_addr) >> 2`, computed modulo 2^ADDR_WIDTH.

Output equations:
- `ready = run && !restarting && in_addr < addr_end && fill < FIFO_WORDS`.
- Push: when `ready && do_write`, the RAM is written at the `in_addr` index and `in_addr += 4`.
- `qpi_wdata` is an asynchronous read at the `qpi_addr` index.

Control, evaluated in priority order:
1. **`!run`:** `in_addr <= addr_start`, `qpi_addr <= addr_start`, `qpi_do_write <= 0`, `restarting <= 1`. Data still in the FIFO is discarded.
2. **`restarting`:** `restarting <= !qpi_is_idle`.
3. **`qpi_next_word`:** `qpi_addr += 4`. Clear `qpi_do_write` if any of these holds:
   - the word index is at a burst boundary (`(idx & (BURST_LEN-1)) == BURST_LEN-1`);
   - `qpi_addr+4 >= addr_end`;
   - `qpi_addr+4 == in_addr` and no push is happening this cycle (underrun guard).
4. **`qpi_is_idle && !qpi_do_write && qpi_addr < addr_end`:** set `qpi_do_write` when either condition holds:
   - `fill >= BURST_LEN - (idx & (BURST_LEN-1))`, i.e. enough words to reach the next boundary;
   - or `in_addr >= addr_end && fill > 0` (tail flush).

`all_done = in_addr >= addr_end && qpi_addr >= addr_end && qpi_is_idle && !qpi_do_write && !restarting`.

## Timing
- **Reset values:**
  - `qpi_do_write=0`, `qpi_addr=0`, `in_addr=0`, `restarting=1`.
  - Therefore `ready=0`. `all_done` follows its equation; it is 0 until rearmed via `run`.
- **Push latency:** a word accepted at edge N is readable on `qpi_wdata` after edge N, and counts toward `fill` from cycle N+1.
- **Burst request:** `qpi_do_write` rises one edge after the start condition holds.
- **Burst end:** `qpi_do_write` falls on the same edge as the final `qpi_next_word`. The controller must not issue another `qpi_next_word` once it sees `qpi_do_write` low.
- **Full FIFO:** `ready=0` at `fill == FIFO_WORDS`. A simultaneous `qpi_next_word` frees a slot from the next cycle on.
- **Empty FIFO:** the underrun guard keeps a burst from reading past `in_addr`.
- **Pointer wrap:** RAM indices wrap naturally. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- **`run` dropping mid-burst:** `qpi_do_write` falls on the next edge. No new burst starts until the controller reports `qpi_is_idle`.
- **Async reset mid-burst:** all registers clear immediately.

## Structure
- Package `qpimem_dma_pkg` holds:
  - the word-size constant `QPI_WORD_BYTES=4`;
  - a function returning words-to-boundary from an index and `BURST_LEN`.
- Sub-module `qpimem_dma_wr_fifomem` is a `FIFO_WORDS`×32 RAM with a synchronous write port and an asynchronous read port.

## Test plan
1. **Full-range transfer.** Rst, `addr_start=0x100`, `addr_end=0x200`, `run=1`, push 64 words with continuous `do_write`, controller model acks every cycle. Required: four bursts of 16 words at 0x100/0x140/0x180/0x1C0; memory matches the pushed data; `all_done=1` after the last word.
2. **Misaligned start.** `addr_start=0x108`, `addr_end=0x148`. Required: the first burst is 14 words, ending at 0x13C; tail bursts follow; no `qpi_addr` reaches 0x148.
3. **Backpressure.** Hold the controller busy (`qpi_is_idle=0`, no acks) while pushing. Required: `ready` falls after exactly 512 accepted words; no data is lost on resume.
4. **Slow producer / tail.** `addr_end=start+0x14`, push 5 words one every 10 cycles. Required: no burst starts until enough words reach the boundary or the tail flush triggers; exactly 5 words are written; no underrun.
5. **Abort.** Drop `run` mid-burst. Required:
   - `qpi_do_write` falls on the next edge;
   - `ready=0` until the controller reports idle;
   - then re-raise `run` with a new `addr_start=0x400`: the transfer restarts at 0x400.
6. **Async reset.** Assert `rst=0` mid-burst, between clock edges. Required: `qpi_do_write=0` and `qpi_addr=0` immediately.
